// File: rtl/hilo_muldiv.sv
// HI/LO owner for the MIPS core: iterative shift-add multiply and restoring divide,
// plus direct MTHI/MTLO writes. One result bit per cycle, sign fix-up in a final cycle.
module hilo_muldiv #(
    parameter int Data_Width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [2:0]            op,
    input  logic [Data_Width-1:0] in0,
    input  logic [Data_Width-1:0] in1,
    output logic                  busy,
    output logic                  done,
    output logic [Data_Width-1:0] hi,
    output logic [Data_Width-1:0] lo
);
    localparam int W  = Data_Width;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, next_state;

    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           is_div, div_zero, sign_q, sign_r;

    logic           accept, req_md, req_div, req_signed, divisor_zero;
    logic [W-1:0]   mag0, mag1, mul_addend;
    logic [W:0]     mul_sum, div_shift;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix;

    // opa holds the multiplicand or divisor; opb shifts out multiplier bits or shifts in quotient bits.
    always_comb begin
        accept       = enable && (state == IDLE);
        req_div      = (op == OP_DIV) || (op == OP_DIVU);
        req_md       = (op == OP_MULT) || (op == OP_MULTU) || req_div;
        req_signed   = (op == OP_MULT) || (op == OP_DIV);
        divisor_zero = (in1 == '0);
        mag0         = (req_signed && in0[W-1]) ? -in0 : in0;
        mag1         = (req_signed && in1[W-1]) ? -in1 : in1;
        mul_addend   = opb[0] ? opa : '0;
        mul_sum      = {1'b0, acc[2*W-1:W]} + {1'b0, mul_addend};
        div_shift    = {acc[W-1:0], opb[W-1]};
        div_diff     = {1'b0, div_shift} - {2'b00, opa};
        prod_fix     = sign_q ? -acc : acc;
        quo_fix      = sign_q ? -opb : opb;
        rem_fix      = sign_r ? -acc[W-1:0] : acc[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept && req_md) next_state = (req_div && divisor_zero) ? FIX : CALC;
            CALC: if (cnt == LAST_ITER) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
        end else begin
            busy <= (next_state != IDLE);
            done <= (state == FIX);
            case (state)
                IDLE: if (accept) begin
                    if (op == OP_MTHI) hi <= in0;
                    if (op == OP_MTLO) lo <= in0;
                    if (req_md) begin
                        // A zero divisor keeps the raw dividend in opb so FIX can return it in HI.
                        opa      <= req_div ? mag1 : mag0;
                        opb      <= req_div ? (divisor_zero ? in0 : mag0) : mag1;
                        acc      <= '0;
                        cnt      <= '0;
                        is_div   <= req_div;
                        div_zero <= req_div && divisor_zero;
                        sign_q   <= req_signed && (in0[W-1] ^ in1[W-1]);
                        sign_r   <= req_signed && in0[W-1];
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        acc <= {{(W-1){1'b0}}, div_diff[W+1] ? div_shift : div_diff[W:0]};
                        opb <= {opb[W-2:0], ~div_diff[W+1]};
                    end else begin
                        acc <= {mul_sum, acc[W-1:1]};
                        opb <= {1'b0, opb[W-1:1]};
                    end
                end
                FIX: begin
                    if (div_zero) begin
                        hi <= opb;
                        lo <= '1;
                    end else if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*W-1:W];
                        lo <= prod_fix[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
